// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the two-requester data-memory arbiter:
//   - arb_state_e : arbiter FSM states (IDLE, OWN0, OWN1)
//   - CPU / DBG   : requester indices into the req/we/lock/gnt/rvalid vectors
//   - MODE_W      : width of the funct3-style access mode field
//   - own_state() : maps a requester index to its ownership state
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam int CPU    = 0;
  localparam int DBG    = 1;
  localparam int MODE_W = 3;

  function automatic arb_state_e own_state(input logic idx);
    return idx ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Two-way round-robin winner selection (purely combinational).
// Ports:
//   req    in  [1:0] request vector (bit 0 = CPU, bit 1 = debug/loader)
//   last   in        index of the most recently granted requester
//   winner out       index of the chosen requester (meaningful when any=1)
//   any    out       at least one request is pending
// -----------------------------------------------------------------------------
module rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       any
);

  always_comb begin
    any = |req;
    // On conflict the requester that did not go last wins; otherwise the
    // single active requester wins (bit 1 decides the index directly).
    if (req == 2'b11) begin
      winner = ~last;
    end else begin
      winner = req[1];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Round-robin arbiter giving a CPU (port 0) and a debug/loader (port 1) shared
// access to a single data-memory port. The access executes combinationally in
// the grant cycle; reads are captured into rdata at the end of that cycle and
// flagged by rvalid on the following cycle.
//
// Optional feature macro: DMEM_ARB_LOCK_EN
//   defined   : lock[x] holds ownership for up to MAX_BURST consecutive beats
//   undefined : lock ignored, every grant lasts one cycle then re-arbitrates
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req/we/lock   [1:0]      per-requester request, write enable, burst hold
//   addr/wdata    [2*WIDTH]  per-requester address / store data (port x at x*WIDTH)
//   mode          [2*3]      per-requester access mode (funct3)
//   gnt           [1:0]      one-hot grant (registered)
//   rvalid        [1:0]      read data valid for that requester
//   rdata         [WIDTH]    registered read data, shared
//   mem_we/addr/wdata/mode   shared data-memory request
//   mem_rdata     [WIDTH]    combinational read data from memory
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [2*WIDTH-1:0]    addr,
  input  logic [2*WIDTH-1:0]    wdata,
  input  logic [2*MODE_W-1:0]   mode,
  input  logic [1:0]            lock,
  output logic [1:0]            gnt,
  output logic [1:0]            rvalid,
  output logic [WIDTH-1:0]      rdata,
  output logic                  mem_we,
  output logic [WIDTH-1:0]      mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  output logic [MODE_W-1:0]     mem_mode,
  input  logic [WIDTH-1:0]      mem_rdata
);

  arb_state_e       state_q, state_d;
  logic             last_q, last_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       rvalid_q, rvalid_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  logic owning;      // currently in OWN0 or OWN1
  logic owner;       // index of the current owner (valid when owning)
  logic active;      // owner is still requesting this cycle
  logic hold;        // burst keeps the current owner without re-arbitration
  logic pick_last;
  logic pick_winner;
  logic pick_any;

  assign owning = (state_q != IDLE);
  assign owner  = (state_q == OWN1);
  assign active = owning && req[owner];

  // While owning, the current owner counts as "last" so the exit decision
  // already favours the other requester.
  assign pick_last = owning ? owner : last_q;

  rr_pick u_rr_pick (
    .req    (req),
    .last   (pick_last),
    .winner (pick_winner),
    .any    (pick_any)
  );

`ifdef DMEM_ARB_LOCK_EN
  localparam int BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BURST - 1);

  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;

  assign hold = active && lock[owner] && (beat_cnt_q < BEAT_LAST);

  // Any cycle that does not extend the burst is a re-arbitration point,
  // so the counter restarts there and never wraps.
  always_comb begin
    beat_cnt_d = hold ? beat_cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end
`else
  logic unused_lock;
  localparam int unused_max_burst = MAX_BURST;

  assign unused_lock = ^lock;
  assign hold        = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    rvalid_d = '0;
    rdata_d  = rdata_q;

    if (!hold) begin
      if (owning) begin
        last_d = owner;
      end
      state_d = pick_any ? own_state(pick_winner) : IDLE;
    end

    // A read issued this cycle is reported on the next one.
    if (active && !we[owner]) begin
      rvalid_d[owner] = 1'b1;
      rdata_d         = mem_rdata;
    end

    gnt_d      = '0;
    gnt_d[CPU] = (state_d == OWN0);
    gnt_d[DBG] = (state_d == OWN1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= 1'(DBG);
      gnt_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // Shared memory port is steered from the owner; reset blocks writes at once.
  always_comb begin
    mem_we    = active && we[owner] && !rst;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_mode  = '0;
    if (owning) begin
      mem_addr  = owner ? addr[2*WIDTH-1:WIDTH]   : addr[WIDTH-1:0];
      mem_wdata = owner ? wdata[2*WIDTH-1:WIDTH]  : wdata[WIDTH-1:0];
      mem_mode  = owner ? mode[2*MODE_W-1:MODE_W] : mode[MODE_W-1:0];
    end
  end

  assign gnt    = gnt_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic [1:0]     req, we, lock;
  logic [2*W-1:0] addr, wdata;
  logic [5:0]     mode;
  logic [1:0]     gnt, rvalid;
  logic [W-1:0]   rdata;
  logic           mem_we;
  logic [W-1:0]   mem_addr, mem_wdata, mem_rdata;
  logic [2:0]     mem_mode;

  dmem_arbiter #(.WIDTH(W), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .mode      (mode),
    .lock      (lock),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_mode  (mem_mode),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [1:0]  lock;
    logic [31:0] mrd;
    logic [1:0]  x_gnt;
    logic [1:0]  x_rv;
    logic        x_mwe;
  } vec_t;

  typedef struct {
    logic        p;
    logic [31:0] d;
  } sb_t;

  vec_t        tbl[$];
  sb_t         sbq[$];
  int          checks = 0;
  int          passes = 0;
  logic [31:0] exp_rdata = 32'h0;

  function automatic vec_t mk(string n, logic r, logic [1:0] q, logic [1:0] w,
                              logic [1:0] l, logic [31:0] d, logic [1:0] g,
                              logic [1:0] v, logic m);
    vec_t t;
    t.name = n; t.rst = r; t.req = q; t.we = w; t.lock = l; t.mrd = d;
    t.x_gnt = g; t.x_rv = v; t.x_mwe = m;
    return t;
  endfunction

  task automatic check32(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  // One cycle: drive after the edge, sample well before the next edge.
  task automatic apply(vec_t v);
    logic [31:0] ea, ed;
    logic [2:0]  em;
    sb_t         s;
    @(posedge clk);
    #1;
    rst = v.rst; req = v.req; we = v.we; lock = v.lock; mem_rdata = v.mrd;
    #3;
    ea = 32'h0; ed = 32'h0; em = 3'd0;
    if (v.x_gnt == 2'b01) begin ea = 32'h10; ed = 32'hAAAA0000; em = 3'd2; end
    if (v.x_gnt == 2'b10) begin ea = 32'h20; ed = 32'h12345678; em = 3'd1; end
    check32({v.name, " gnt"},       {30'd0, gnt},    {30'd0, v.x_gnt});
    check32({v.name, " rvalid"},    {30'd0, rvalid}, {30'd0, v.x_rv});
    check32({v.name, " mem_we"},    {31'd0, mem_we}, {31'd0, v.x_mwe});
    check32({v.name, " mem_addr"},  mem_addr,        ea);
    check32({v.name, " mem_wdata"}, mem_wdata,       ed);
    check32({v.name, " mem_mode"},  {29'd0, mem_mode}, {29'd0, em});
    if (rvalid != 2'b00) begin
      if (sbq.size() == 0) begin
        checks++;
        $display("FAIL %s rvalid: got %b expected no read outstanding", v.name, rvalid);
      end else begin
        s = sbq.pop_front();
        check32({v.name, " rvalid_port"}, {30'd0, rvalid}, s.p ? 32'd2 : 32'd1);
        exp_rdata = s.d;
      end
    end
    check32({v.name, " rdata"}, rdata, exp_rdata);
    $display("%-18s req=%b we=%b lock=%b gnt=%b rvalid=%b mem_we=%b addr=%h rdata=%h",
             v.name, v.req, v.we, v.lock, gnt, rvalid, mem_we, mem_addr, rdata);
    for (int p = 0; p < 2; p++) begin
      if (v.x_gnt[p] && v.req[p] && !v.we[p] && !v.rst) begin
        s.p = (p == 1);
        s.d = v.mrd;
        sbq.push_back(s);
      end
    end
    if (v.rst) begin
      exp_rdata = 32'h0;
      sbq.delete();
    end
  endtask

  initial begin
    rst = 1'b1; req = 2'b00; we = 2'b00; lock = 2'b00; mem_rdata = 32'h0;
    addr  = {32'h00000020, 32'h00000010};
    wdata = {32'h12345678, 32'hAAAA0000};
    mode  = {3'd1, 3'd2};

    //                  name               rst req    we     lock   mem_rdata     gnt    rvalid mem_we
    tbl.push_back(mk("rst_idle",          1, 2'b00, 2'b00, 2'b00, 32'h0,        2'b00, 2'b00, 0));
    tbl.push_back(mk("req_cpu",           0, 2'b01, 2'b00, 2'b00, 32'hDEADBEEF, 2'b00, 2'b00, 0));
    tbl.push_back(mk("cpu_grant_read",    0, 2'b01, 2'b00, 2'b00, 32'hDEADBEEF, 2'b01, 2'b00, 0));
    tbl.push_back(mk("cpu_rvalid",        0, 2'b00, 2'b00, 2'b00, 32'h11111111, 2'b01, 2'b01, 0));
    tbl.push_back(mk("idle_hold",         0, 2'b00, 2'b00, 2'b00, 32'h0,        2'b00, 2'b00, 0));
    tbl.push_back(mk("conflict_req",      0, 2'b11, 2'b00, 2'b00, 32'h0,        2'b00, 2'b00, 0));
    tbl.push_back(mk("rr_dbg_first",      0, 2'b11, 2'b00, 2'b00, 32'h22222222, 2'b10, 2'b00, 0));
    tbl.push_back(mk("rr_cpu",            0, 2'b11, 2'b00, 2'b00, 32'h33333333, 2'b01, 2'b10, 0));
    tbl.push_back(mk("dbg_write",         0, 2'b11, 2'b10, 2'b00, 32'h44444444, 2'b10, 2'b01, 1));
    tbl.push_back(mk("cpu_write",         0, 2'b11, 2'b01, 2'b00, 32'h0,        2'b01, 2'b00, 1));
    tbl.push_back(mk("dbg_req_drop",      0, 2'b01, 2'b11, 2'b00, 32'h0,        2'b10, 2'b00, 0));
    tbl.push_back(mk("cpu_req_drop",      0, 2'b00, 2'b00, 2'b01, 32'h0,        2'b01, 2'b00, 0));
    tbl.push_back(mk("rst_mid",           1, 2'b11, 2'b11, 2'b00, 32'h0,        2'b00, 2'b00, 0));
    tbl.push_back(mk("post_rst_conflict", 0, 2'b11, 2'b00, 2'b00, 32'h55555555, 2'b00, 2'b00, 0));
    tbl.push_back(mk("cpu_wins_first",    0, 2'b11, 2'b00, 2'b00, 32'h66666666, 2'b01, 2'b00, 0));
    tbl.push_back(mk("dbg_next",          0, 2'b11, 2'b00, 2'b00, 32'h77777777, 2'b10, 2'b01, 0));
    tbl.push_back(mk("drain",             0, 2'b00, 2'b00, 2'b00, 32'h0,        2'b01, 2'b10, 0));
    tbl.push_back(mk("idle_end",          0, 2'b00, 2'b00, 2'b00, 32'h0,        2'b00, 2'b00, 0));

    repeat (2) @(posedge clk);
    foreach (tbl[i]) apply(tbl[i]);

`ifdef DMEM_ARB_LOCK_EN
    // Locked CPU burst: four beats, then forced hand-over to the debug port.
    apply(mk("lk_rst",      1, 2'b00, 2'b00, 2'b00, 32'h0,        2'b00, 2'b00, 0));
    apply(mk("lk_req",      0, 2'b11, 2'b00, 2'b01, 32'hA1A1A1A1, 2'b00, 2'b00, 0));
    apply(mk("lk_beat0",    0, 2'b11, 2'b00, 2'b01, 32'hA2A2A2A2, 2'b01, 2'b00, 0));
    apply(mk("lk_beat1",    0, 2'b11, 2'b00, 2'b01, 32'hA3A3A3A3, 2'b01, 2'b01, 0));
    apply(mk("lk_beat2",    0, 2'b11, 2'b00, 2'b01, 32'hA4A4A4A4, 2'b01, 2'b01, 0));
    apply(mk("lk_beat3",    0, 2'b11, 2'b00, 2'b01, 32'hA5A5A5A5, 2'b01, 2'b01, 0));
    apply(mk("lk_rearb",    0, 2'b11, 2'b00, 2'b01, 32'hA6A6A6A6, 2'b10, 2'b01, 0));
    apply(mk("lk_back_cpu", 0, 2'b00, 2'b00, 2'b00, 32'h0,        2'b01, 2'b10, 0));
    apply(mk("lk_idle",     0, 2'b00, 2'b00, 2'b00, 32'h0,        2'b00, 2'b00, 0));
`else
    // Lock is ignored: the conflict still alternates every cycle.
    apply(mk("nl_req",      0, 2'b11, 2'b00, 2'b11, 32'hB1B1B1B1, 2'b00, 2'b00, 0));
    apply(mk("nl_dbg",      0, 2'b11, 2'b00, 2'b11, 32'hB2B2B2B2, 2'b10, 2'b00, 0));
    apply(mk("nl_cpu",      0, 2'b11, 2'b00, 2'b11, 32'hB3B3B3B3, 2'b01, 2'b10, 0));
    apply(mk("nl_dbg2",     0, 2'b00, 2'b00, 2'b11, 32'h0,        2'b10, 2'b01, 0));
    apply(mk("nl_idle",     0, 2'b00, 2'b00, 2'b00, 32'h0,        2'b00, 2'b00, 0));
`endif

    // Reset during the second beat of a locked write: write suppressed, then idle.
    apply(mk("wb_req",       0, 2'b01, 2'b01, 2'b01, 32'h0, 2'b00, 2'b00, 0));
    apply(mk("wb_beat0",     0, 2'b01, 2'b01, 2'b01, 32'h0, 2'b01, 2'b00, 1));
    apply(mk("wb_rst_beat1", 1, 2'b01, 2'b01, 2'b01, 32'h0, 2'b01, 2'b00, 0));
    apply(mk("wb_after_rst", 0, 2'b00, 2'b00, 2'b00, 32'h0, 2'b00, 2'b00, 0));

    checks++;
    if (sbq.size() == 0) passes++;
    else $display("FAIL sb_drain: got %0d reads outstanding expected 0", sbq.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter: WIDTH, 32, data/address width.
REQ-002 The block SHALL have parameter: MAX_BURST, 4, max consecutive locked grant cycles per owner (>=1).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: req  input  2  per-requester request; bit 0 = CPU, bit 1 = debug/loader.
REQ-006 Port: we  input  2  per-requester write enable.
REQ-007 Port: addr  input  2 x WIDTH  per-requester byte address.
REQ-008 Port: wdata  input  2 x WIDTH  per-requester store data.
REQ-009 Port: mode  input  2 x 3  per-requester access mode (funct3 encoding).
REQ-010 Port: lock  input  2  per-requester burst-hold request.
REQ-011 Port: gnt  output  2  one-hot grant; access executes in the grant cycle.
REQ-012 Port: rvalid  output  2  read data valid for that requester.
REQ-013 Port: rdata  output  WIDTH  registered read data, shared by both requesters.
REQ-014 Port: mem_we, mem_addr, mem_wdata, mem_mode  output  1/WIDTH/WIDTH/3  shared data-memory port.
REQ-015 Port: mem_rdata  input  WIDTH  combinational read data from data memory.

Function
REQ-016 FSM states SHALL be IDLE, OWN0, OWN1; gnt[x]=1 exactly in OWNx, gnt=0 in IDLE.
REQ-017 From IDLE, a request sampled at edge N SHALL produce gnt at cycle N+1 (one-cycle grant latency).
REQ-018 In OWNx, mem_* SHALL be driven combinationally from port x (mem_we = we[x] & req[x]); in IDLE mem_we=0, mem_addr=0, mem_wdata=0, mem_mode=0.
REQ-019 A read in grant cycle (we[x]=0) SHALL capture mem_rdata into rdata at that cycle's end; rvalid[x]=1 for exactly the following cycle; rdata holds until the next read.
REQ-020 Arbitration SHALL be round-robin: on conflict, the requester not most recently granted wins; last-owner pointer updates on every exit from OWNx.
REQ-021 On leaving OWNx with the other requester pending, the next state SHALL be OWN(other) with no IDLE bubble.
REQ-022 On leaving OWNx with only req[x] pending, the next state SHALL be OWNx again; with no request, IDLE.
REQ-023 Burst: in OWNx with lock[x]&req[x] and beat_cnt < MAX_BURST-1, the FSM SHALL stay in OWNx and increment beat_cnt regardless of the other request.
REQ-024 beat_cnt SHALL clear on any state change and on reaching MAX_BURST-1 (forced re-arbitration); it never wraps.
REQ-025 If req[x] drops while in OWNx, that cycle SHALL perform no memory write and produce no rvalid.

Reset
REQ-026 When rst=1 at an edge: state=IDLE, gnt=0, rvalid=0, rdata=0, beat_cnt=0, last-owner=1 (CPU wins first conflict).
REQ-027 While rst=1, mem_we SHALL be forced 0 combinationally; a burst in progress is aborted with no further beats.

Configuration
REQ-028 Macro DMEM_ARB_LOCK_EN defined: lock inputs and beat_cnt honoured per REQ-023/024.
REQ-029 Macro DMEM_ARB_LOCK_EN undefined: lock ignored, beat_cnt absent, every grant is a single cycle followed by re-arbitration.

Structure
REQ-030 Package dmem_arb_pkg SHALL hold the state enum typedef, requester index constants (CPU=0, DBG=1) and the mode width constant (3).
REQ-031 Winner selection SHALL be a sub-module rr_pick (2-way round-robin picker: req, last -> winner, any).

Verification
REQ-032 Reset then req=2'b01, we=0, addr0=0x10, mem_rdata=0xDEADBEEF -> gnt=01 next cycle, rvalid=01 cycle after, rdata=0xDEADBEEF.
REQ-033 req=2'b11 held, lock=0 -> gnt sequence 01,10,01,10 with no IDLE cycles.
REQ-034 DMEM_ARB_LOCK_EN, MAX_BURST=4, req=11, lock0=1 -> gnt=01 for 4 cycles, then 10.
REQ-035 Port 1 write we1=1, addr1=0x20, wdata1=0x12345678 -> mem_we=1, mem_addr=0x20, mem_wdata=0x12345678 only in the gnt=10 cycle; rvalid stays 0.
REQ-036 rst asserted in 2nd beat of a locked write burst -> mem_we=0 that cycle, next cycle state IDLE, gnt=0, rvalid=0.
